// File: rtl/pipeline_issue_arbiter_pkg.sv
// pipeline_issue_pkg: shared types and widths for the pipeline issue arbiter
// Widths follow the default configuration; top-level parameters must agree with them.
package pipeline_issue_pkg;
    localparam int P_NREQ = 4;
    localparam int P_STAGES = 5;
    localparam int P_DW = 12;
    localparam int TAG_W = $clog2(P_NREQ);
    localparam int CNT_W = $clog2(P_STAGES + 2);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic valid;
        logic [TAG_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/pipeline_issue_arbiter_if.sv
// pipeline_issue_arbiter_if: requester, response, flush and pipeline-side signals of the issue arbiter
interface pipeline_issue_arbiter_if #(parameter int NREQ = 4, parameter int DW = 12);
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
    logic [NREQ*DW-1:0] req_data;
    logic flush_req, flush_done, pipe_enable, busy;
    logic [DW-1:0] pipe_data_in, pipe_data_out, rsp_data;
    modport master (
        output req_valid, req_data, flush_req, pipe_data_out,
        input req_ready, rsp_valid, rsp_data, flush_done, pipe_enable, pipe_data_in, busy
    );
    modport slave (
        input req_valid, req_data, flush_req, pipe_data_out,
        output req_ready, rsp_valid, rsp_data, flush_done, pipe_enable, pipe_data_in, busy
    );
endinterface

// File: rtl/pipeline_issue_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer moves past each winner
module rr_arbiter
    import pipeline_issue_pkg::*;
#(
    parameter int N = P_NREQ,
    parameter int W = TAG_W
) (
    input  logic         clk,
    input  logic         pon_rst_n_i,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] win,
    output logic         any
);
    logic [W-1:0] ptr;
    logic [N-1:0] rot;
    // rot[i] is requester ptr+i (mod N), so the lowest set bit is the winner
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int i = 0; i < N; i++)
            if (en && !any && rot[i]) begin
                any = 1'b1;
                win = (int'(ptr) + i >= N) ? W'(int'(ptr) + i - N) : W'(int'(ptr) + i);
            end
        gnt = N'(any) << win;
    end
    always_ff @(posedge clk or negedge pon_rst_n_i)
        if (!pon_rst_n_i) ptr <= '0;
        else if (any) ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
endmodule

// File: rtl/pipeline_issue_arbiter.sv
// pipeline_issue_arbiter: round-robin issue into a fixed-latency pipeline with tag-steered responses
// The pipeline cannot mark bubbles, so a shadow tag pipeline carries {valid, requester} alongside it.
module pipeline_issue_arbiter
    import pipeline_issue_pkg::*;
#(
    parameter int NREQ = P_NREQ,
    parameter int STAGE_COUNT = P_STAGES,
    parameter int DATA_WIDTH = P_DW
) (
    input logic clk,
    input logic pon_rst_n_i,
    pipeline_issue_arbiter_if.slave bus
);
    state_t state;
    tag_t [STAGE_COUNT-1:0] tags;
    tag_t tag_out;
    logic [CNT_W-1:0] inflight, cnt_nxt;
    logic [TAG_W-1:0] win;
    logic issue;

    rr_arbiter #(.N(NREQ), .W(TAG_W)) u_arb (
        .clk(clk),
        .pon_rst_n_i(pon_rst_n_i),
        .en(state == RUN && !bus.flush_req),
        .req(bus.req_valid),
        .gnt(bus.req_ready),
        .win(win),
        .any(issue)
    );

    assign cnt_nxt = inflight + CNT_W'(issue) - CNT_W'(tag_out.valid);
    assign bus.pipe_enable = state != IDLE;
    assign bus.busy = state != IDLE;
    assign bus.rsp_data = bus.pipe_data_out;
    assign bus.rsp_valid = NREQ'(tag_out.valid) << tag_out.id;

    // Leaving RUN/DRAIN looks at the post-update count so the pipeline stops right after the last response
    always_ff @(posedge clk or negedge pon_rst_n_i)
        if (!pon_rst_n_i) begin
            state <= IDLE;
            bus.flush_done <= 1'b0;
            bus.pipe_data_in <= '0;
            inflight <= '0;
        end else begin
            bus.flush_done <= 1'b0;
            bus.pipe_data_in <= issue ? bus.req_data[win*DATA_WIDTH +: DATA_WIDTH] : '0;
            inflight <= cnt_nxt;
            case (state)
                IDLE:
                    if (bus.flush_req) bus.flush_done <= 1'b1;
                    else if (|bus.req_valid) state <= RUN;
                RUN:
                    if (bus.flush_req) state <= DRAIN;
                    else if (!(|bus.req_valid) && cnt_nxt == '0) state <= IDLE;
                DRAIN:
                    if (cnt_nxt == '0) begin
                        state <= IDLE;
                        bus.flush_done <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end

    always_ff @(posedge clk or negedge pon_rst_n_i)
        if (!pon_rst_n_i) begin
            tags <= '0;
            tag_out <= '0;
        end else begin
            tags <= bus.pipe_enable ? {tags[STAGE_COUNT-2:0], issue, win} : '0;
            tag_out <= tags[STAGE_COUNT-1];
        end
endmodule

// File: doc/pipeline_issue_arbiter.md
# pipeline_issue_arbiter

Round-robin issue controller that shares one fixed-latency processing pipeline between NREQ requesters. Grants at most one request per cycle and drives the pipeline's enable and input. Tracks each issued word with a shadow tag pipeline, because the pipeline itself marks every enabled cycle valid and cannot represent bubbles. Steers each result back to its originating requester and supports a drain/flush sequence before the pipeline is disabled.

## Interface
- NREQ, 4, number of requesters (2..8)
- STAGE_COUNT, 5, pipeline stage count S; must match the attached pipeline
- DATA_WIDTH, 12, datapath width DW
- clk  in  1  clock
- pon_rst_n_i  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_data  in  NREQ*DW  packed request words; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready
- flush_req  in  1  level; stop issuing and drain
- flush_done  out  1  one-cycle pulse when drain completes
- pipe_enable  out  1  to pipeline enable
- pipe_data_in  out  DW  to pipeline input
- pipe_data_out  in  DW  from pipeline output register
- rsp_valid  out  NREQ  one-hot response strobe, no backpressure
- rsp_data  out  DW  equals pipe_data_out
- busy  out  1  state != IDLE

## Operation
- FSM states and transitions:
  - IDLE: pipe_enable=0, no grants. Any req_valid with flush_req=0 -> RUN. flush_req=1 -> flush_done pulse next cycle, stay IDLE.
  - RUN: pipe_enable=1. Grant only when flush_req=0.
    - flush_req=1 -> DRAIN.
    - No req_valid, no issue this cycle, and inflight==0 -> IDLE.
  - DRAIN: pipe_enable=1, no grants. When inflight==0 -> IDLE and pulse flush_done.
- Arbitration:
  - Round-robin pointer starts at 0 after reset.
  - Searches pointer, pointer+1, … mod NREQ; first requester with req_valid wins.
  - On a grant, pointer moves to winner+1 mod NREQ. No grant: pointer holds.
- pipe_data_in is the granted requester's word, otherwise 0 (bubble).
- Tag pipeline:
  - S slots of {valid, id[TAG_W]}; shifts when pipe_enable=1; slot0 gets {issue, winner}.
  - All slots clear when pipe_enable=0, mirroring the pipeline's valid clearing.
  - Tag output register loads from slot S-1 every cycle.
  - rsp_valid[id] = tag_out.valid.
- inflight counter:
  - Width clog2(S+2).
  - +1 on issue, −1 on a cycle with rsp_valid, unchanged when both occur.
  - Maximum value S+1; overflow is impossible.
- Arithmetic: the pipeline returns input + (S−1) mod 2^DW; this block does no arithmetic on data.
- pipe_enable is never deasserted while inflight != 0. Dropping it would corrupt in-flight data.

## Timing
- req_ready is combinational from state, pointer, req_valid and flush_req. The other outputs are registered or decoded from state.
- Issue accepted in cycle c → rsp_valid in cycle c+S+1. Throughput is one per cycle.
- IDLE→RUN costs one cycle: the first grant is at the earliest one cycle after req_valid rises in IDLE.
- flush_req asserted in cycle f blocks grants in cycle f. flush_done is asserted in the cycle after the last response.
- Reset values: req_ready=0, pipe_enable=0, pipe_data_in=0, rsp_valid=0, flush_done=0, busy=0. Tags, pointer and inflight are 0.
- Reset mid-operation drops all in-flight words without responses. The pipeline shares the same reset.

## Structure
- Package pipeline_issue_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - TAG_W = clog2(NREQ);
  - CNT_W = clog2(STAGE_COUNT+2);
  - the tag struct {valid, id}.
- Sub-module rr_arbiter: NREQ-wide round-robin grant with pointer register and enable input. The top level holds the FSM, the tag pipeline and the counter.

## Test plan
All scenarios use S=5 and DW=12.
- Single request: req 0, data 0x0FF, issued in cycle 1 → rsp_valid=0001 in cycle 7, rsp_data=0x103. Returns to IDLE, busy=0 in cycle 8.
- All four requesters held valid → grants 0,1,2,3,0… on consecutive cycles. Responses arrive in the same order, 6 cycles later each.
- Wrap-around: req 2, data 0xFFE → rsp_valid=0100, rsp_data=0x002.
- Flush while 3 words are in flight with requests pending → no further req_ready. The 3 responses are delivered, then one flush_done pulse, then IDLE.
- Sparse traffic with gaps of 2 cycles → no rsp_valid in bubble cycles and pipe_enable stays high until inflight==0.
- Reset asserted while 4 words are in flight → all outputs 0 immediately, no responses after release. The pointer restarts at requester 0.
